pe_multicast_ctrl: RTL and testbench

- Per-PE multicast controller. Sits directly upstream of one processing element (PE) in the array.
- Accepts a tagged ifmap/filter word stream from the global buffer bus and keeps only words addressed to this PE.
- Drives the PE's ifmap/filter load enables, one burst of FILTER_SIZE ifmaps and FILTER_SIZE filters at a time.
- Paces bursts using the PE's ready output.

---
 rtl/pe_multicast_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_pe_multicast_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_multicast_ctrl.sv
// Per-PE multicast controller: filters the tagged bus stream for this PE and
// paces ifmap/filter bursts into it. Optional DROP_COUNT_EN adds drop_count.
module pe_multicast_ctrl #(
    parameter int BITWIDTH        = 16,
    parameter int TAG_WIDTH       = 4,
    parameter int FILTER_SIZE     = 3,
    parameter int FIFO_ADDR_WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic                       cfg_valid,
    input  logic [TAG_WIDTH-1:0]       cfg_id,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [BITWIDTH-1:0] in_data,
    input  logic [TAG_WIDTH-1:0]       in_tag,
    input  logic                       in_type,
    input  logic                       pe_ready,
    output logic                       ifmap_enable,
    output logic                       filter_enable,
    output logic signed [BITWIDTH-1:0] ifmap_out,
    output logic signed [BITWIDTH-1:0] filter_out,
`ifdef DROP_COUNT_EN
    output logic [7:0]                 drop_count,
`endif
    output logic                       burst_done
);

    localparam int DEPTH   = 1 << FIFO_ADDR_WIDTH;
    localparam int ENTRY_W = 1 + TAG_WIDTH + BITWIDTH;
    localparam int CNT_W   = $clog2(FILTER_SIZE + 1);
    localparam logic [CNT_W-1:0] FS_C = CNT_W'(FILTER_SIZE);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_READY
    } state_t;

    state_t state;

    logic [ENTRY_W-1:0]         mem [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr;
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr;
    logic [FIFO_ADDR_WIDTH:0]   count;

    logic [TAG_WIDTH-1:0] my_id;
    logic [CNT_W-1:0]     ifmap_cnt;
    logic [CNT_W-1:0]     filter_cnt;

    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 pop_drop;
    logic                 pop_if;
    logic                 pop_fl;
    logic [ENTRY_W-1:0]   head;
    logic                 head_type;
    logic [TAG_WIDTH-1:0] head_tag;
    logic [BITWIDTH-1:0]  head_data;
    logic                 tag_match;
    logic                 if_full;
    logic                 fl_full;
    logic                 burst_full;

    // count only reaches DEPTH when full, so its MSB is the full flag
    assign full     = count[FIFO_ADDR_WIDTH];
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign push     = in_valid && in_ready;

    assign head      = mem[rd_ptr];
    assign head_type = head[ENTRY_W-1];
    assign head_tag  = head[BITWIDTH +: TAG_WIDTH];
    assign head_data = head[BITWIDTH-1:0];
    assign tag_match = (head_tag == my_id) || (head_tag == '1);

    assign if_full    = (ifmap_cnt == FS_C);
    assign fl_full    = (filter_cnt == FS_C);
    assign burst_full = if_full && fl_full;

    always_comb begin
        pop_drop = 1'b0;
        pop_if   = 1'b0;
        pop_fl   = 1'b0;
        if (state == LOAD && !empty && !burst_full) begin
            priority case (1'b1)
                !tag_match:                        pop_drop = 1'b1;
                pe_ready && !head_type && !if_full: pop_if   = 1'b1;
                pe_ready && head_type && !fl_full:  pop_fl   = 1'b1;
                default: ;
            endcase
        end
    end

    assign pop = pop_drop || pop_if || pop_fl;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_type, in_tag, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            state         <= IDLE;
            my_id         <= '0;
            ifmap_cnt     <= '0;
            filter_cnt    <= '0;
            ifmap_enable  <= 1'b0;
            filter_enable <= 1'b0;
            ifmap_out     <= '0;
            filter_out    <= '0;
            burst_done    <= 1'b0;
        end else begin
            ifmap_enable  <= pop_if;
            filter_enable <= pop_fl;
            burst_done    <= 1'b0;
            if (pop_if) begin
                ifmap_out <= head_data;
                ifmap_cnt <= ifmap_cnt + CNT_W'(1);
            end
            if (pop_fl) begin
                filter_out <= head_data;
                filter_cnt <= filter_cnt + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        my_id <= cfg_id;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (burst_full) begin
                        burst_done <= 1'b1;
                        state      <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (!pe_ready) begin
                        state <= WAIT_READY;
                    end
                end
                WAIT_READY: begin
                    if (pe_ready) begin
                        ifmap_cnt  <= '0;
                        filter_cnt <= '0;
                        state      <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DROP_COUNT_EN
    always_ff @(posedge clk) begin
        if (rstb) begin
            drop_count <= '0;
        end else if (pop_drop && drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pe_multicast_ctrl.sv
// Scoreboard bench for pe_multicast_ctrl: directed scenarios plus randomized
// bursts, checked against an order-based reference model.
module tb_pe_multicast_ctrl;

    logic        clk = 1'b0;
    logic        rstb = 1'b1;
    logic        cfg_valid = 1'b0;
    logic [3:0]  cfg_id = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [3:0]  in_tag = '0;
    logic        in_type = 1'b0;
    logic        pe_ready;
    logic        ifmap_enable;
    logic        filter_enable;
    logic [15:0] ifmap_out;
    logic [15:0] filter_out;
    logic        burst_done;
`ifdef DROP_COUNT_EN
    logic [7:0]  drop_count;
`endif

    logic pe_auto = 1'b0;
    logic pe_man  = 1'b1;
    logic pe_rand = 1'b1;
    assign pe_ready = pe_auto ? pe_rand : pe_man;

    pe_multicast_ctrl dut (
        .clk(clk),
        .rstb(rstb),
        .cfg_valid(cfg_valid),
        .cfg_id(cfg_id),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_tag(in_tag),
        .in_type(in_type),
        .pe_ready(pe_ready),
        .ifmap_enable(ifmap_enable),
        .filter_enable(filter_enable),
        .ifmap_out(ifmap_out),
        .filter_out(filter_out),
`ifdef DROP_COUNT_EN
        .drop_count(drop_count),
`endif
        .burst_done(burst_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int strobes = 0;
    int bursts_seen = 0;
    int model_drops = 0;
    logic [3:0] model_id = '0;
    logic [16:0] exp_q[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // monitor: strobes are popped against the scoreboard in order
    initial begin
        int since;
        logic [15:0] last_if;
        logic [15:0] last_fl;
        logic [16:0] e;
        since = 0;
        last_if = '0;
        last_fl = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rstb) begin
                since = 0;
                last_if = '0;
                last_fl = '0;
            end else begin
                if (ifmap_enable && filter_enable) begin
                    chk("enable_exclusive", 32'd1, 32'd0);
                end
                if (ifmap_enable || filter_enable) begin
                    strobes++;
                    since++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_strobe", {15'd0, filter_enable,
                            ifmap_enable ? ifmap_out : filter_out}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("strobe", {15'd0, filter_enable,
                            filter_enable ? filter_out : ifmap_out}, {15'd0, e});
                    end
                    if (ifmap_enable) last_if = ifmap_out;
                    if (filter_enable) last_fl = filter_out;
                end
                if (!ifmap_enable) chk("ifmap_hold", {16'd0, ifmap_out}, {16'd0, last_if});
                if (!filter_enable) chk("filter_hold", {16'd0, filter_out}, {16'd0, last_fl});
                if (burst_done) begin
                    chk("burst_len", since, 6);
                    since = 0;
                    bursts_seen++;
                end
            end
        end
    end

    // PE model: ready in LOAD with occasional stalls, drops out for MAC after a burst
    initial begin
        forever begin
            @(negedge clk);
            if (burst_done) begin
                pe_rand = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                pe_rand = 1'b1;
            end else begin
                pe_rand = ($urandom_range(0, 7) != 0);
            end
        end
    end

    task automatic push(input logic t, input logic [3:0] tag, input logic [15:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_type  = t;
        in_tag   = tag;
        in_data  = d;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("push_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            @(negedge clk);
            in_valid = 1'b0;
            if (tag == model_id || tag == 4'hF) exp_q.push_back({t, d});
            else model_drops++;
        end
    endtask

    task automatic wait_bursts(input int target);
        int n;
        n = 0;
        while (bursts_seen < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("burst_reached", bursts_seen >= target, 1);
    endtask

    task automatic handshake();
        pe_man = 1'b0;
        repeat (2) @(negedge clk);
        pe_man = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic configure(input logic [3:0] id);
        cfg_valid = 1'b1;
        cfg_id    = id;
        @(negedge clk);
        cfg_valid = 1'b0;
        model_id  = id;
    endtask

    task automatic do_reset();
        rstb = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        model_drops = 0;
        chk("rst_ifmap_enable", ifmap_enable, 0);
        chk("rst_filter_enable", filter_enable, 0);
        chk("rst_burst_done", burst_done, 0);
        chk("rst_ifmap_out", ifmap_out, 0);
        chk("rst_filter_out", filter_out, 0);
        chk("rst_in_ready", in_ready, 1);
`ifdef DROP_COUNT_EN
        chk("rst_drop_count", drop_count, 0);
`endif
        @(negedge clk);
        rstb = 1'b0;
    endtask

    initial begin
        int s0;
        int base;
        logic tp[6];
        logic tmp;
        logic [3:0] bad;

        repeat (2) @(negedge clk);
        do_reset();
        @(negedge clk);

        // basic burst, ifmaps then filters
        configure(4'd5);
        push(0, 5, 1); push(0, 5, 2); push(0, 5, 3);
        push(1, 5, 4); push(1, 5, 5); push(1, 5, 6);
        wait_bursts(1);

        // extra word after burst_done waits for the PE handshake
        s0 = strobes;
        push(0, 5, 9);
        repeat (5) @(negedge clk);
        chk("pacing_hold", strobes, s0);
        handshake();

        // mismatch filtering and broadcast
        push(1, 3, 100); push(0, 5, 10); push(0, 3, 101);
        push(1, 5, 12); push(0, 15, 7); push(1, 3, 102);
        push(1, 5, 13); push(1, 5, 14);
        wait_bursts(2);
`ifdef DROP_COUNT_EN
        chk("drop_count", drop_count, model_drops);
`endif
        handshake();

        // backpressure: PE not ready, buffer fills
        pe_man = 1'b0;
        s0 = strobes;
        push(0, 5, 20); push(0, 5, 21); push(1, 5, 22); push(1, 5, 23);
        chk("in_ready_full", in_ready, 0);
        repeat (5) @(negedge clk);
        chk("backpressure_hold", strobes, s0);
        pe_man = 1'b1;
        push(0, 5, 24); push(1, 5, 25);
        wait_bursts(3);
        chk("scoreboard_drained_a", exp_q.size(), 0);

        // randomized bursts with a random tag and a stalling PE
        do_reset();
        configure(4'($urandom_range(0, 14)));
        pe_auto = 1'b1;
        base = bursts_seen;
        for (int b = 0; b < 6; b++) begin
            tp = '{0, 0, 0, 1, 1, 1};
            for (int i = 5; i > 0; i--) begin
                int j;
                j = $urandom_range(0, i);
                tmp = tp[i];
                tp[i] = tp[j];
                tp[j] = tmp;
            end
            for (int i = 0; i < 6; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    do bad = 4'($urandom_range(0, 14)); while (bad == model_id);
                    push(1'($urandom_range(0, 1)), bad, 16'($urandom));
                end
                push(tp[i], ($urandom_range(0, 4) == 0) ? 4'hF : model_id, 16'($urandom));
            end
        end
        wait_bursts(base + 6);
        chk("scoreboard_drained_b", exp_q.size(), 0);
`ifdef DROP_COUNT_EN
        chk("drop_count_rand", drop_count, (model_drops > 255) ? 255 : model_drops);
`endif

        // reset mid-burst with two ifmaps delivered and two words buffered
        pe_auto = 1'b0;
        pe_man  = 1'b1;
        handshake();
        push(0, model_id, 30); push(0, model_id, 31);
        repeat (4) @(negedge clk);
        pe_man = 1'b0;
        push(0, model_id, 32); push(1, model_id, 33);
        repeat (3) @(negedge clk);
        chk("pre_reset_strobes", exp_q.size(), 2);
        do_reset();
        s0 = strobes;
        repeat (3) @(negedge clk);
        configure(4'd5);
        pe_man = 1'b1;
        repeat (10) @(negedge clk);
        chk("stale_words", strobes, s0);
        base = bursts_seen;
        push(0, 5, 40); push(1, 5, 41); push(0, 5, 42);
        push(1, 5, 43); push(0, 5, 44); push(1, 5, 45);
        wait_bursts(base + 1);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained_c", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
